lsu_wb_master: RTL and testbench

Load/store bus master for the multicycle RISC-V core. It sits between the core's memory stage and the Wishbone data memory slave. It turns one RV32I load or store request (byte, halfword or word) into Wishbone classic cycles against a 32-bit word-only slave that has no byte selects:
- Loads are extracted and sign- or zero-extended.
- Sub-word stores are done as read-modify-write.
- Misaligned accesses are rejected without touching the bus.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_wb_master_align.sv | 41 ++++
 rtl/lsu_wb_master.sv | 149 ++++++++++++++
 tb/tb_lsu_wb_master.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the Wishbone load/store unit: funct3 codes, FSM states
// and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } lsu_state_t;

  // Unsupported funct3 codes (including LBU/LHU encodings used as stores)
  // are reported the same way as misaligned addresses.
  function automatic logic is_misaligned(input logic we, input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_LB:   bad = 1'b0;
      F3_LH:   bad = addr_lo[0];
      F3_LW:   bad = |addr_lo;
      F3_LBU:  bad = we;
      F3_LHU:  bad = we | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_wb_master_align.sv
// Byte-lane logic: load extraction with sign/zero extension and
// read-modify-write merge of sub-word store data into the old word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = old_word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? old_word[31:16] : old_word[15:0];

    load_data = old_word;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'h0, byte_sel};
      F3_LHU:  load_data = {16'h0, half_sel};
      default: load_data = old_word;
    endcase

    store_word = old_word;
    case (funct3)
      F3_SB: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_SH: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_wb_master.sv
// RV32I load/store master for a word-only Wishbone classic slave; sub-word
// stores use read-modify-write. Optional ack timeout under LSU_TIMEOUT_EN.
module lsu_wb_master
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  lsu_state_t  state, state_n;
  logic [31:0] addr_q, wdata_q, dat_q, rdata_q;
  logic [2:0]  f3_q;
  logic        we_q, err_q;
  logic        req_bad, busy, timeout;
  logic [31:0] load_data, store_word;

  lsu_align u_align (
    .old_word   (wb_dat_i),
    .wdata      (wdata_q),
    .addr_lo    (addr_q[1:0]),
    .funct3     (f3_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  assign req_bad = is_misaligned(req_we, req_funct3, req_addr[1:0]);
  assign busy    = (state == ST_RD) || (state == ST_WR);

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt;

  // Abort on the edge that closes the TIMEOUT_CYCLES-th unacknowledged strobe cycle.
  assign timeout = busy && !wb_ack_i && (tcnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)                          tcnt <= '0;
    else if (!busy || state_n != state)  tcnt <= '0;
    else                                 tcnt <= tcnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad)                              state_n = ST_RESP;
          else if (req_we && req_funct3 == F3_SW)   state_n = ST_WR;
          else                                      state_n = ST_RD;
        end
      end
      ST_RD: begin
        if (wb_ack_i)     state_n = we_q ? ST_WR : ST_RESP;
        else if (timeout) state_n = ST_RESP;
      end
      ST_WR:   if (wb_ack_i || timeout) state_n = ST_RESP;
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
            we_q    <= req_we;
            if (req_bad) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else if (req_we && req_funct3 == F3_SW) begin
              dat_q <= req_wdata;
            end
          end
        end
        ST_RD: begin
          if (wb_ack_i) begin
            if (we_q) dat_q <= store_word;
            else begin
              rdata_q <= load_data;
              err_q   <= 1'b0;
            end
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        ST_WR: begin
          if (wb_ack_i) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign wb_cyc_o  = busy;
  assign wb_stb_o  = busy;
  assign wb_we_o   = (state == ST_WR);
  assign wb_addr_o = {addr_q[31:2], 2'b00};
  assign wb_dat_o  = dat_q;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Directed bench for lsu_wb_master with a one-wait-state word-memory slave.
module tb_lsu_wb_master;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_addr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i;

  int checks = 0;
  int errors = 0;

  lsu_wb_master #(.TIMEOUT_CYCLES(16)) dut (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_addr_o  (wb_addr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i)
  );

  always #5 wb_clk = ~wb_clk;

  // Slave: acks one cycle after seeing stb, ignores stb while its ack is high.
  logic [31:0] mem [0:1023];
  logic        ack_en = 1'b1;
  int          n_reads = 0, n_writes = 0, cyc_cycles = 0;
  logic [31:0] last_wdata = '0;

  always @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wb_ack_i <= 1'b0;
      wb_dat_i <= '0;
    end else begin
      wb_ack_i <= ack_en && wb_stb_o && !wb_ack_i;
      if (ack_en && wb_stb_o && !wb_ack_i) begin
        if (wb_we_o) begin
          mem[wb_addr_o[11:2]] <= wb_dat_o;
          last_wdata <= wb_dat_o;
          n_writes <= n_writes + 1;
        end else begin
          wb_dat_i <= mem[wb_addr_o[11:2]];
          n_reads <= n_reads + 1;
        end
      end
    end
  end

  always @(posedge wb_clk) if (wb_cyc_o) cyc_cycles <= cyc_cycles + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int n = 0;
    @(negedge wb_clk);
    while (!req_ready && n < 40) begin
      @(negedge wb_clk);
      n++;
    end
    if (!req_ready) check("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge wb_clk);
    #1 req_valid = 1'b0;
  endtask

  // lat counts negedges after the accept edge until rsp_valid (0 = never).
  task automatic wait_rsp(output int lat, output int stbc, output int rdy);
    lat = 0; stbc = 0; rdy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge wb_clk);
      if (wb_stb_o) stbc++;
      if (req_ready) rdy++;
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat, stbc, rdy, r0, w0, c0, found, pulses;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h40] = 32'h8899AABB;
    req_valid = 0; req_we = 0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    wb_rst = 1'b1;
    #3;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_cyc",   {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("rst_we",    {31'b0, wb_we_o}, 32'd0);
    check("rst_valid", {30'b0, rsp_valid, rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_addr",  wb_addr_o, 32'd0);
    check("rst_dat",   wb_dat_o, 32'd0);
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;

    issue(0, 3'b000, 32'h101, 0); wait_rsp(lat, stbc, rdy);
    check("lb_lat", lat, 3); check("lb_data", rsp_rdata, 32'hFFFFFFAA);
    check("lb_err", {31'b0, rsp_err}, 0); check("lb_ready_low", rdy, 0);

    issue(0, 3'b100, 32'h101, 0); wait_rsp(lat, stbc, rdy);
    check("lbu_lat", lat, 3); check("lbu_data", rsp_rdata, 32'h000000AA);

    issue(0, 3'b001, 32'h102, 0); wait_rsp(lat, stbc, rdy);
    check("lh_lat", lat, 3); check("lh_data", rsp_rdata, 32'hFFFF8899);

    issue(0, 3'b101, 32'h100, 0); wait_rsp(lat, stbc, rdy);
    check("lhu_data", rsp_rdata, 32'h0000AABB);

    issue(0, 3'b010, 32'h100, 0); wait_rsp(lat, stbc, rdy);
    check("lw_data", rsp_rdata, 32'h8899AABB);

    r0 = n_reads; w0 = n_writes;
    issue(1, 3'b000, 32'h102, 32'h12345655); wait_rsp(lat, stbc, rdy);
    check("sb_lat", lat, 5); check("sb_err", {31'b0, rsp_err}, 0);
    check("sb_reads", n_reads - r0, 1); check("sb_writes", n_writes - w0, 1);
    check("sb_wdat", last_wdata, 32'h8855AABB); check("sb_mem", mem[10'h40], 32'h8855AABB);
    check("sb_rdata", rsp_rdata, 0);

    c0 = cyc_cycles;
    issue(0, 3'b010, 32'h102, 0); wait_rsp(lat, stbc, rdy);
    check("lw_mis_lat", lat, 1); check("lw_mis_err", {31'b0, rsp_err}, 1);
    check("lw_mis_rdata", rsp_rdata, 0);
    issue(1, 3'b001, 32'h103, 32'hFFFF); wait_rsp(lat, stbc, rdy);
    check("sh_mis_lat", lat, 1); check("sh_mis_err", {31'b0, rsp_err}, 1);
    issue(0, 3'b011, 32'h100, 0); wait_rsp(lat, stbc, rdy);
    check("f3_011_err", {31'b0, rsp_err}, 1);
    issue(1, 3'b100, 32'h100, 0); wait_rsp(lat, stbc, rdy);
    check("sbu_err", {31'b0, rsp_err}, 1);
    check("mis_no_cyc", cyc_cycles - c0, 0);
    check("mis_mem_kept", mem[10'h40], 32'h8855AABB);

    issue(1, 3'b010, 32'h200, 32'hDEADBEEF); wait_rsp(lat, stbc, rdy);
    check("sw_lat", lat, 3); check("sw_err", {31'b0, rsp_err}, 0);
    check("sw_rdata", rsp_rdata, 0); check("sw_ready_low", rdy, 0);
    check("sw_mem", mem[10'h80], 32'hDEADBEEF);
    issue(0, 3'b010, 32'h200, 0); wait_rsp(lat, stbc, rdy);
    check("b2b_lw_lat", lat, 3); check("b2b_lw_data", rsp_rdata, 32'hDEADBEEF);

    issue(1, 3'b001, 32'h202, 32'h1111CAFE); wait_rsp(lat, stbc, rdy);
    check("sh_lat", lat, 5); check("sh_mem", mem[10'h80], 32'hCAFEBEEF);

`ifdef LSU_TIMEOUT_EN
    ack_en = 1'b0;
    issue(0, 3'b010, 32'h0, 0); wait_rsp(lat, stbc, rdy);
    check("to_stb_cycles", stbc, 16); check("to_lat", lat, 17);
    check("to_err", {31'b0, rsp_err}, 1); check("to_rdata", rsp_rdata, 0);
    ack_en = 1'b1;
    @(negedge wb_clk);
`endif

    issue(1, 3'b000, 32'h104, 32'h77); found = 0;
    for (int i = 0; i < 20; i++) begin
      if (wb_we_o) begin found = 1; break; end
      @(negedge wb_clk);
    end
    check("rst_mid_reached_wr", found, 1);
    #2 wb_rst = 1'b1;
    #1 check("rst_mid_cyc", {30'b0, wb_cyc_o, wb_stb_o}, 0);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge wb_clk);
      if (rsp_valid) pulses++;
    end
    check("rst_mid_no_rsp", pulses, 0);
    check("rst_mid_ready", {31'b0, req_ready}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
